// File: rtl/mips_ifetch_if.sv
// Instruction-memory port of the MIPS fetch unit.
// Handshake: the fetch unit raises imem_req with imem_addr and holds both stable until
// the memory returns imem_ack=1 with imem_rdata in the same cycle; ack with req=0 is ignored.
interface mips_ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/mips_ifetch.sv
// Instruction fetch unit for the single-cycle MIPS core: holds the PC, fetches over req/ack,
// presents instr/op/pc to execute and computes the next PC from branch/jump/zero on accept.
module mips_ifetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  mips_ifetch_if.master      imem,
  output logic [31:0]        instr,
  output logic [5:0]         op,
  output logic [31:0]        pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [31:0]        retired,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] npc;

  assign op        = instr[31:26];
  assign state_dbg = state;

  // Next PC is only consumed on an accept in S_VALID, so branch/jump/zero are don't-care elsewhere.
  always_comb begin
    p4     = pc + 32'd4;
    br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    npc    = p4;
    if (jump) begin
      npc = {p4[31:28], instr[25:0], 2'b00};
    end else if (branch && zero) begin
      npc = p4 + br_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= PC_RESET;
      instr          <= 32'h0;
      instr_valid    <= 1'b0;
      pc             <= PC_RESET;
      retired        <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          imem.imem_req  <= 1'b1;
          imem.imem_addr <= pc;
          state          <= S_REQ;
        end
        S_REQ: begin
          if (imem.imem_ack) begin
            instr         <= imem.imem_rdata;
            imem.imem_req <= 1'b0;
            instr_valid   <= 1'b1;
            state         <= S_VALID;
          end
        end
        S_VALID: begin
          // The request for the next word is issued in the same edge as the accept.
          if (instr_ready) begin
            pc             <= npc;
            imem.imem_addr <= npc;
            imem.imem_req  <= 1'b1;
            instr_valid    <= 1'b0;
            retired        <= retired + 32'd1;
            state          <= S_REQ;
          end
        end
        default: begin
          imem.imem_req <= 1'b0;
          instr_valid   <= 1'b0;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_ifetch.sv
// Self-checking bench for mips_ifetch: memory driver, accept driver, fetched-word scoreboard.
module tb_mips_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        jump;
  logic        zero;
  logic [31:0] retired;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mips_ifetch_if bus();

  mips_ifetch #(.PC_RESET(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (bus.master),
    .instr      (instr),
    .op         (op),
    .pc         (pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch     (branch),
    .jump       (jump),
    .zero       (zero),
    .retired    (retired),
    .state_dbg  (state_dbg)
  );

  function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] w,
                                            input logic br, input logic jp, input logic z);
    logic [31:0] s;
    s = p + 32'd4;
    if (jp) return {s[31:28], w[25:0], 2'b00};
    if (br && z) return s + {{14{w[15]}}, w[15:0], 2'b00};
    return s;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_req(input int budget);
    int n;
    n = 0;
    while (n < budget && bus.imem_req !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.imem_req !== 1'b1) begin
      bad++;
      $display("FAIL req_timeout: imem_req=%b required 1 within %0d cycles", bus.imem_req, budget);
    end
  endtask

  task automatic do_ack(input logic [31:0] w);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = w;
    exp_q.push_back(w);
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
  endtask

  task automatic accept(input logic br, input logic jp, input logic z);
    instr_ready = 1'b1;
    branch = br;
    jump   = jp;
    zero   = z;
    @(negedge clk);
    instr_ready = 1'b0;
    branch = 1'($urandom);
    jump   = 1'($urandom);
    zero   = 1'($urandom);
  endtask

  task automatic step(input logic [31:0] w, input logic br, input logic jp, input logic z);
    wait_req(8);
    do_ack(w);
    void'(exp_q.pop_front());
    accept(br, jp, z);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    instr_ready = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    branch = 1'b1; jump = 1'b1; zero = 1'b1;
    repeat (3) @(negedge clk);
    bus.imem_ack = 1'b0;
    total++;
    if ({bus.imem_req, instr_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_ctrl: req/valid=%b required 00", {bus.imem_req, instr_valid});
    end
    total++;
    if ({bus.imem_addr, pc, instr, retired} !== 128'h0) begin
      bad++; $display("FAIL reset_regs: addr=%h pc=%h instr=%h retired=%h required all 0",
                      bus.imem_addr, pc, instr, retired);
    end
    total++;
    if (op !== 6'h0 || state_dbg !== 2'd0) begin
      bad++; $display("FAIL reset_op_state: op=%h state=%0d required 0/0", op, state_dbg);
    end
  endtask

  task automatic test_first_fetch();
    logic [31:0] w;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL first_req: req=%b addr=%h valid=%b required 1/0/0",
                      bus.imem_req, bus.imem_addr, instr_valid);
    end
    do_ack(32'h3C01_1234);
    w = exp_q.pop_front();
    total++;
    if (instr_valid !== 1'b1 || instr !== w || op !== 6'h0F || pc !== 32'h0) begin
      bad++; $display("FAIL first_valid: valid=%b instr=%h op=%h pc=%h required 1/%h/0f/0",
                      instr_valid, instr, op, pc, w);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] w;
    accept(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      instr_ready = 1'b1;
      total++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL wait_hold[%0d]: req=%b addr=%h valid=%b required 1/4/0",
                        i, bus.imem_req, bus.imem_addr, instr_valid);
      end
      @(negedge clk);
    end
    instr_ready = 1'b0;
    total++;
    if (retired !== 32'd1 || pc !== 32'h4) begin
      bad++; $display("FAIL ready_ignored: retired=%0d pc=%h required 1/4", retired, pc);
    end
    w = $urandom;
    do_ack(w);
    w = exp_q.pop_front();
    total++;
    if (instr_valid !== 1'b1 || instr !== w || pc !== 32'h4) begin
      bad++; $display("FAIL wait_valid: valid=%b instr=%h pc=%h required 1/%h/4",
                      instr_valid, instr, pc, w);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    do_reset();
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    instr_ready = 1'b1;
    wait_req(2);
    for (int i = 0; i < 3; i++) begin
      wait_req(0);
      total++;
      if (bus.imem_addr !== 32'(i * 4)) begin
        bad++; $display("FAIL b2b_addr[%0d]: addr=%h required %h", i, bus.imem_addr, 32'(i * 4));
      end
      do_ack($urandom);
      w = exp_q.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr !== w) begin
        bad++; $display("FAIL b2b_instr[%0d]: valid=%b instr=%h required 1/%h", i, instr_valid, instr, w);
      end
      @(negedge clk);
    end
    instr_ready = 1'b0;
    total++;
    if (retired !== 32'd3 || bus.imem_addr !== 32'hC) begin
      bad++; $display("FAIL b2b_retired: retired=%0d addr=%h required 3/c", retired, bus.imem_addr);
    end
  endtask

  task automatic test_branch();
    do_reset();
    step(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    step(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    step(32'h1000_0003, 1'b1, 1'b0, 1'b1);
    wait_req(0);
    total++;
    if (bus.imem_addr !== 32'h18) begin
      bad++; $display("FAIL beq_taken: addr=%h required 00000018", bus.imem_addr);
    end
    do_reset();
    step(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    step(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    step(32'h1000_0003, 1'b1, 1'b0, 1'b0);
    wait_req(0);
    total++;
    if (bus.imem_addr !== 32'hC) begin
      bad++; $display("FAIL beq_not_taken: addr=%h required 0000000c", bus.imem_addr);
    end
    do_reset();
    step(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    step(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    step(32'h1000_FFFF, 1'b1, 1'b0, 1'b1);
    wait_req(0);
    total++;
    if (bus.imem_addr !== 32'h8) begin
      bad++; $display("FAIL beq_backward: addr=%h required 00000008", bus.imem_addr);
    end
  endtask

  task automatic test_jump();
    do_reset();
    for (int i = 0; i < 4; i++) step(32'h0000_0020, 1'b0, 1'b0, 1'b0);
    wait_req(0);
    total++;
    if (bus.imem_addr !== 32'h10) begin
      bad++; $display("FAIL jump_setup: addr=%h required 00000010", bus.imem_addr);
    end
    step(32'h0800_0040, 1'b1, 1'b1, 1'b1);
    wait_req(0);
    total++;
    if (bus.imem_addr !== 32'h100 || retired !== 32'd5) begin
      bad++; $display("FAIL jump_target: addr=%h retired=%0d required 00000100/5", bus.imem_addr, retired);
    end
  endtask

  task automatic test_pc_wrap();
    logic [31:0] w;
    do_reset();
    step(32'h1000_FFFE, 1'b1, 1'b0, 1'b1);
    wait_req(0);
    do_ack(32'h0000_0020);
    w = exp_q.pop_front();
    total++;
    if (pc !== 32'hFFFF_FFFC || instr !== w) begin
      bad++; $display("FAIL wrap_pc: pc=%h instr=%h required fffffffc/%h", pc, instr, w);
    end
    accept(1'b0, 1'b0, 1'b0);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_next: req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_hold_and_reset();
    logic [31:0] w;
    do_reset();
    wait_req(4);
    do_ack($urandom);
    w = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      bus.imem_ack = 1'b1;
      bus.imem_rdata = ~w;
      branch = 1'b1; jump = 1'b1; zero = 1'b1;
      total++;
      if (instr_valid !== 1'b1 || instr !== w || pc !== 32'h0 || bus.imem_req !== 1'b0) begin
        bad++; $display("FAIL hold[%0d]: valid=%b instr=%h pc=%h req=%b required 1/%h/0/0",
                        i, instr_valid, instr, pc, bus.imem_req, w);
      end
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    accept(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.imem_req !== 1'b0 || pc !== 32'h0 || retired !== 32'd0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL mid_req_reset: req=%b pc=%h retired=%0d valid=%b required 0/0/0/0",
                      bus.imem_req, pc, retired, instr_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      bad++; $display("FAIL refetch: req=%b addr=%h required 1/00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] mpc;
    logic [31:0] w;
    logic br, jp, z;
    do_reset();
    mpc = 32'h0;
    for (int n = 0; n < 25; n++) begin
      wait_req(8);
      total++;
      if (bus.imem_addr !== mpc) begin
        bad++; $display("FAIL rnd_addr[%0d]: addr=%h required %h", n, bus.imem_addr, mpc);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = $urandom;
      br = 1'($urandom); jp = 1'($urandom_range(0, 3) == 0); z = 1'($urandom);
      do_ack(w);
      w = exp_q.pop_front();
      total++;
      if (instr_valid !== 1'b1 || instr !== w || pc !== mpc) begin
        bad++; $display("FAIL rnd_instr[%0d]: valid=%b instr=%h pc=%h required 1/%h/%h",
                        n, instr_valid, instr, pc, w, mpc);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      accept(br, jp, z);
      mpc = model_npc(mpc, w, br, jp, z);
    end
    total++;
    if (retired !== 32'd25) begin
      bad++; $display("FAIL rnd_retired: retired=%0d required 25", retired);
    end
  endtask

  initial begin
    rst = 1'b1;
    instr_ready = 1'b0;
    branch = 1'b0; jump = 1'b0; zero = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_back_to_back();
    test_branch();
    test_jump();
    test_pc_wrap();
    test_hold_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
